// File: rtl/tt_um_power_seq.sv
// Burst sequencer for the 7+7-bit power-test adder: operands come from pins, an LFSR or a max-toggle pattern, only during ON bursts.
// Latency: a config write lands 2 edges after the strobe is first sampled high; operand-to-sum latency is 1 cycle.
// Backpressure: none; ena=0 freezes everything except the strobe synchronizer/edge detector, so strobes seen then are lost.
// Ports: clk, rst_n (async, active-low), ena; ui_in = {strobe, addr[1:0], data[4:0]} and PIN operand A in [6:0];
//        uio_in[6:0] = PIN operand B; uo_out = registered A+B; uio_out[7] = BUSY_ON; uio_oe = 8'h80.
module tt_um_power_seq #(
    parameter logic [13:0] LFSR_SEED = 14'h0001,
    parameter logic [4:0]  DEF_ON    = 5'd16,
    parameter logic [4:0]  DEF_OFF   = 5'd16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_PIN  = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;
    localparam logic [1:0] MODE_TOG  = 2'd3;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [4:0]  cnt_nxt;
    logic [4:0]  on_len;
    logic [4:0]  off_len;
    logic [1:0]  mode;
    logic        tog;
    logic [13:0] lfsr;
    logic [13:0] lfsr_nxt;
    logic [6:0]  op_a;
    logic [6:0]  op_b;

    logic        strb_s1;
    logic        strb_s2;
    logic        strb_prev;
    logic        wr_pulse;
    logic        wr_on;
    logic        wr_off;
    logic        wr_mode;
    logic        cmd_start;
    logic        cmd_stop;
    logic        unused_ok;

    assign unused_ok = &{1'b0, uio_in[7]};

    // Synchronizer and edge flop keep running while ena=0 so a strobe
    // rising during a freeze is consumed then and never replayed later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_s1   <= 1'b0;
            strb_s2   <= 1'b0;
            strb_prev <= 1'b0;
        end else begin
            strb_s1   <= ui_in[7];
            strb_s2   <= strb_s1;
            strb_prev <= strb_s2;
        end
    end

    assign wr_pulse  = ena & strb_s2 & ~strb_prev;
    assign wr_on     = wr_pulse && (ui_in[6:5] == 2'd0);
    assign wr_off    = wr_pulse && (ui_in[6:5] == 2'd1);
    assign wr_mode   = wr_pulse && (ui_in[6:5] == 2'd2);
    assign cmd_stop  = wr_pulse && (ui_in[6:5] == 2'd3) && ui_in[1];
    assign cmd_start = wr_pulse && (ui_in[6:5] == 2'd3) && ui_in[0] && !ui_in[1];

    // Taps 14,13,12,2 -> bits 13,12,11,1; maximal length, never hits zero.
    assign lfsr_nxt = {lfsr[12:0], lfsr[13] ^ lfsr[12] ^ lfsr[11] ^ lfsr[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ena) begin
            case (state)
                ON: begin
                    if (cnt != 5'd0) begin
                        cnt_nxt = cnt - 5'd1;
                    end else if (off_len != 5'd0) begin
                        state_nxt = OFF;
                        cnt_nxt   = off_len - 5'd1;
                    end else begin
                        cnt_nxt = on_len - 5'd1;
                    end
                end
                OFF: begin
                    if (cnt == 5'd0) begin
                        state_nxt = ON;
                        cnt_nxt   = on_len - 5'd1;
                    end else begin
                        cnt_nxt = cnt - 5'd1;
                    end
                end
                default: begin
                end
            endcase
            // Commands override the burst timing; START from IDLE needs a
            // usable mode and a nonzero burst, a restart from ON/OFF does not.
            if (cmd_stop) begin
                state_nxt = IDLE;
            end else if (cmd_start &&
                         (state != IDLE || (mode != 2'd0 && on_len != 5'd0))) begin
                state_nxt = ON;
                cnt_nxt   = on_len - 5'd1;
            end
        end
    end

    // Operands, LFSR, sum and config. Operand updates use the mode held
    // before this edge, so a MODE write affects only the following update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= 7'd0;
            op_b    <= 7'd0;
            uo_out  <= 8'd0;
            lfsr    <= LFSR_SEED;
            tog     <= 1'b0;
            on_len  <= DEF_ON;
            off_len <= DEF_OFF;
            mode    <= 2'd0;
        end else if (ena) begin
            uo_out <= {1'b0, op_a} + {1'b0, op_b};
            if (state == ON) begin
                case (mode)
                    MODE_PIN: begin
                        op_a <= ui_in[6:0];
                        op_b <= uio_in[6:0];
                    end
                    MODE_LFSR: begin
                        lfsr <= lfsr_nxt;
                        op_a <= lfsr_nxt[6:0];
                        op_b <= lfsr_nxt[13:7];
                    end
                    MODE_TOG: begin
                        // tog=0 gives all-ones, so the first update is 7'h7F
                        op_a <= {7{~tog}};
                        op_b <= {7{~tog}};
                        tog  <= ~tog;
                    end
                    default: begin
                    end
                endcase
            end
            if (wr_on) begin
                on_len <= ui_in[4:0];
            end
            if (wr_off) begin
                off_len <= ui_in[4:0];
            end
            if (wr_mode) begin
                mode <= ui_in[1:0];
                tog  <= 1'b0;
            end
        end
    end

    assign uio_out = {(state == ON), 7'd0};
    assign uio_oe  = 8'h80;

endmodule

// File: tb/tb_tt_um_power_seq.sv
// Self-checking bench for tt_um_power_seq against a phase/length reference model.
// Latency: model advances one clock per cycle() call; outputs compared 1ns after the rising edge.
// Backpressure: none; ena dropouts and reset pulses are driven directly by the tests.
module tb_tt_um_power_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tt_um_power_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    // Reference model: phase plus cycles left in the phase, config, operands.
    localparam int P_IDLE = 0;
    localparam int P_ON   = 1;
    localparam int P_OFF  = 2;

    int          m_ph, m_left, m_on, m_off, m_mode, m_a, m_b, m_sum, m_tog;
    logic [13:0] m_lfsr;
    bit          m_s1, m_s2, m_pv;

    task automatic model_reset();
        m_ph = P_IDLE; m_left = 0; m_on = 16; m_off = 16; m_mode = 0;
        m_a = 0; m_b = 0; m_sum = 0; m_tog = 0; m_lfsr = 14'h0001;
        m_s1 = 0; m_s2 = 0; m_pv = 0;
    endtask

    task automatic cycle();
        int ph, left, on, off, mode, a, b, sum, tog, dat;
        logic [13:0] l;
        bit wr, s1;
        ph = m_ph; left = m_left; on = m_on; off = m_off; mode = m_mode;
        a = m_a; b = m_b; sum = m_sum; tog = m_tog; l = m_lfsr;
        wr = m_s2 && !m_pv;
        s1 = ui_in[7];
        if (ena) begin
            sum = m_a + m_b;
            if (m_ph == P_ON) begin
                if (m_mode == 1) begin
                    a = ui_in[6:0]; b = uio_in[6:0];
                end else if (m_mode == 2) begin
                    l = {m_lfsr[12:0], ^(m_lfsr & 14'h3802)};
                    a = l[6:0]; b = l[13:7];
                end else if (m_mode == 3) begin
                    a = (m_tog % 2 == 0) ? 127 : 0; b = a; tog = m_tog + 1;
                end
                if (m_left > 1) left = m_left - 1;
                else if (m_off != 0) begin ph = P_OFF; left = m_off; end
                else left = m_on;
            end else if (m_ph == P_OFF) begin
                if (m_left > 1) left = m_left - 1;
                else begin ph = P_ON; left = m_on; end
            end
            if (wr) begin
                dat = ui_in[4:0];
                case (ui_in[6:5])
                    2'd0: on = dat;
                    2'd1: off = dat;
                    2'd2: begin mode = dat % 4; tog = 0; end
                    default: begin
                        if (dat & 2) ph = P_IDLE;
                        else if (dat & 1) begin
                            if (m_ph != P_IDLE || (m_mode != 0 && m_on != 0)) begin
                                ph = P_ON; left = m_on;
                            end
                        end
                    end
                endcase
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_ph = ph; m_left = left; m_on = on; m_off = off; m_mode = mode;
            m_a = a; m_b = b; m_sum = sum; m_tog = tog; m_lfsr = l;
            m_pv = m_s2; m_s2 = m_s1; m_s1 = s1;
        end
    endtask

    // Strobe a config write; returns just after the edge where it lands.
    task automatic write_cfg(input logic [1:0] addr, input logic [4:0] data);
        ui_in = {1'b0, addr, data};
        repeat (3) cycle();
        ui_in[7] = 1'b1;
        repeat (3) cycle();
        ui_in[7] = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_uio;
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        model_reset();
        repeat (3) cycle();
        n_checks++;
        if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out: got %h want 00", uo_out); end
        n_checks++;
        if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out: got %h want 00", uio_out); end
        n_checks++;
        if (uio_oe !== 8'h80) begin n_fail++; $display("FAIL reset_uio_oe: got %h want 80", uio_oe); end
        #2 rst_n = 1'b1;
        write_cfg(2'd3, 5'd1);
        repeat (3) begin
            exp_uio = (m_ph == P_ON) ? 8'h80 : 8'h00;
            n_checks++;
            if (uio_out !== 8'h00 || uio_out !== exp_uio)
                begin n_fail++; $display("FAIL reset_start_mode0: got %h want 00", uio_out); end
            cycle();
        end
    endtask

    task automatic test_pin();
        logic [7:0] exp_uio;
        write_cfg(2'd2, 5'd1);
        write_cfg(2'd0, 5'd4);
        write_cfg(2'd1, 5'd0);
        write_cfg(2'd3, 5'd1);
        n_checks++;
        if (uio_out !== 8'h80) begin n_fail++; $display("FAIL pin_busy_start: got %h want 80", uio_out); end
        ui_in = 8'h7F; uio_in = 8'h01;
        cycle();
        cycle();
        n_checks++;
        if (uo_out !== 8'h80) begin n_fail++; $display("FAIL pin_sum_fixed: got %h want 80", uo_out); end
        for (int i = 0; i < 60; i++) begin
            ui_in = {1'b0, 7'($urandom)};
            uio_in = 8'($urandom);
            cycle();
            exp_uio = (m_ph == P_ON) ? 8'h80 : 8'h00;
            n_checks++;
            if (uo_out !== 8'(m_sum)) begin n_fail++; $display("FAIL pin_sum[%0d]: got %0d want %0d", i, uo_out, m_sum); end
            n_checks++;
            if (uio_out !== 8'h80 || uio_out !== exp_uio)
                begin n_fail++; $display("FAIL pin_busy[%0d]: got %h want 80", i, uio_out); end
        end
    endtask

    task automatic test_toggle();
        int busy_tab[8] = '{1, 1, 0, 0, 1, 1, 1, 0};
        int sum_tab[8]  = '{-1, 254, 0, 254, 254, 254, 0, 254};
        logic [7:0] exp_uio;
        write_cfg(2'd3, 5'd2);
        write_cfg(2'd2, 5'd3);
        write_cfg(2'd0, 5'd3);
        write_cfg(2'd1, 5'd2);
        write_cfg(2'd3, 5'd1);
        n_checks++;
        if (uio_out !== 8'h80) begin n_fail++; $display("FAIL tog_busy_start: got %h want 80", uio_out); end
        for (int i = 0; i < 8; i++) begin
            cycle();
            n_checks++;
            if (uio_out[7] !== 1'(busy_tab[i])) begin n_fail++; $display("FAIL tog_busy[%0d]: got %b want %0d", i, uio_out[7], busy_tab[i]); end
            if (sum_tab[i] >= 0) begin
                n_checks++;
                if (uo_out !== 8'(sum_tab[i])) begin n_fail++; $display("FAIL tog_sum[%0d]: got %0d want %0d", i, uo_out, sum_tab[i]); end
            end
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            exp_uio = (m_ph == P_ON) ? 8'h80 : 8'h00;
            n_checks++;
            if (uo_out !== 8'(m_sum) || uio_out !== exp_uio)
                begin n_fail++; $display("FAIL tog_model[%0d]: got %0d/%h want %0d/%h", i, uo_out, uio_out, m_sum, exp_uio); end
        end
    endtask

    task automatic test_lfsr();
        logic [7:0] exp_uio;
        write_cfg(2'd3, 5'd2);
        write_cfg(2'd2, 5'd2);
        write_cfg(2'd0, 5'd31);
        write_cfg(2'd1, 5'd1);
        write_cfg(2'd3, 5'd1);
        for (int i = 0; i < 500; i++) begin
            uio_in = 8'($urandom);
            cycle();
            exp_uio = (m_ph == P_ON) ? 8'h80 : 8'h00;
            n_checks++;
            if (uo_out !== 8'(m_sum)) begin n_fail++; $display("FAIL lfsr_sum[%0d]: got %0d want %0d", i, uo_out, m_sum); end
            n_checks++;
            if (uio_out !== exp_uio) begin n_fail++; $display("FAIL lfsr_busy[%0d]: got %h want %h", i, uio_out, exp_uio); end
        end
    endtask

    task automatic test_commands();
        int held;
        write_cfg(2'd3, 5'd3);
        n_checks++;
        if (uio_out !== 8'h00 || m_ph != P_IDLE) begin n_fail++; $display("FAIL cmd_both_stop: got %h want 00", uio_out); end
        write_cfg(2'd2, 5'd1);
        write_cfg(2'd0, 5'd0);
        write_cfg(2'd3, 5'd1);
        cycle();
        n_checks++;
        if (uio_out !== 8'h00) begin n_fail++; $display("FAIL cmd_onlen0_start: got %h want 00", uio_out); end
        write_cfg(2'd0, 5'd5);
        write_cfg(2'd1, 5'd0);
        write_cfg(2'd3, 5'd1);
        n_checks++;
        if (uio_out !== 8'h80) begin n_fail++; $display("FAIL cmd_start: got %h want 80", uio_out); end
        write_cfg(2'd3, 5'd2);
        n_checks++;
        if (uio_out !== 8'h00) begin n_fail++; $display("FAIL cmd_stop_mid_on: got %h want 00", uio_out); end
        cycle();
        held = m_sum;
        for (int i = 0; i < 6; i++) begin
            ui_in = {1'b0, 7'($urandom)};
            uio_in = 8'($urandom);
            cycle();
            n_checks++;
            if (uo_out !== 8'(held) || uio_out !== 8'h00)
                begin n_fail++; $display("FAIL cmd_hold[%0d]: got %0d/%h want %0d/00", i, uo_out, uio_out, held); end
        end
    endtask

    task automatic test_disturb();
        logic [7:0] snap_sum;
        logic [7:0] snap_uio;
        logic [7:0] exp_uio;
        write_cfg(2'd2, 5'd3);
        write_cfg(2'd0, 5'd6);
        write_cfg(2'd1, 5'd3);
        write_cfg(2'd3, 5'd1);
        cycle();
        cycle();
        snap_sum = 8'(m_sum);
        snap_uio = (m_ph == P_ON) ? 8'h80 : 8'h00;
        ena = 1'b0;
        ui_in = 8'hE2;   // STOP strobe during the freeze must be lost
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++;
            if (uo_out !== snap_sum || uio_out !== snap_uio)
                begin n_fail++; $display("FAIL freeze[%0d]: got %0d/%h want %0d/%h", i, uo_out, uio_out, snap_sum, snap_uio); end
        end
        ena = 1'b1;
        ui_in = 8'h00;
        for (int i = 0; i < 30; i++) begin
            cycle();
            exp_uio = (m_ph == P_ON) ? 8'h80 : 8'h00;
            n_checks++;
            if (uo_out !== 8'(m_sum) || uio_out !== exp_uio)
                begin n_fail++; $display("FAIL resume[%0d]: got %0d/%h want %0d/%h", i, uo_out, uio_out, m_sum, exp_uio); end
        end
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h80)
            begin n_fail++; $display("FAIL async_reset: got %h/%h/%h want 00/00/80", uo_out, uio_out, uio_oe); end
        #1 rst_n = 1'b1;
        write_cfg(2'd3, 5'd1);
        cycle();
        n_checks++;
        if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_mode_cleared: got %h want 00", uio_out); end
        write_cfg(2'd2, 5'd1);
        write_cfg(2'd3, 5'd1);
        for (int i = 0; i < 40; i++) begin
            ui_in = {1'b0, 7'($urandom)};
            uio_in = 8'($urandom);
            cycle();
            exp_uio = (m_ph == P_ON) ? 8'h80 : 8'h00;
            n_checks++;
            if (uo_out !== 8'(m_sum) || uio_out !== exp_uio)
                begin n_fail++; $display("FAIL default_lens[%0d]: got %0d/%h want %0d/%h", i, uo_out, uio_out, m_sum, exp_uio); end
        end
    endtask

    initial begin
        test_reset();
        test_pin();
        test_toggle();
        test_lfsr();
        test_commands();
        test_disturb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_um_power_seq.md
# tt_um_power_seq

Burst sequencer for the tile's 7-bit + 7-bit power-test adder. It decides what the adder adds and when it switches: operands come from pins, an internal LFSR, or a max-toggle pattern. Operands change only during programmable ON bursts separated by quiet OFF gaps, so supply current can be modulated in a controlled way. It is a standalone TinyTapeout user tile and is configured through `ui_in`.

## Interface

Parameters:
- `LFSR_SEED`, default 14'h0001: reset value of the 14-bit LFSR. Must be nonzero.
- `DEF_ON`, default 5'd16: reset value of ON_LEN.
- `DEF_OFF`, default 5'd16: reset value of OFF_LEN.

Ports:
- `clk`  in  1: single clock; every register is on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ena`  in  1: tile enable. When 0, all state except the `ui_in[7]` synchronizer freezes.
- `ui_in`  in  8:
  - [7] is the config write strobe.
  - [6:5] is the register address; [4:0] is write data.
  - [6:0] is also operand A in PIN mode.
- `uo_out`  out  8: registered sum A+B, 8-bit, cannot overflow (max 254).
- `uio_in`  in  8: [6:0] is operand B in PIN mode; [7] is unused.
- `uio_out`  out  8: [7] = BUSY_ON (state==ON); [6:0] = 0.
- `uio_oe`  out  8: constant 8'h80.

## Operation

Config registers, written on a strobe; ADDR = `ui_in[6:5]`:
- ADDR 0: ON_LEN = data[4:0].
- ADDR 1: OFF_LEN = data[4:0].
- ADDR 2: MODE = data[1:0]. 0 = NONE, 1 = PIN, 2 = LFSR, 3 = TOGGLE.
- ADDR 3: command, self-clearing. data[0] = START, data[1] = STOP. STOP wins if both are set.

Strobe path:
- `ui_in[7]` passes through a 2-flop synchronizer, then a rising-edge detect.
- The write occurs on the edge where the detect pulse is high. `ui_in[6:0]` is sampled at that edge.

FSM states are IDLE, ON and OFF; CNT is a 5-bit down-counter.
- IDLE → ON on START when MODE≠0 and ON_LEN≠0; CNT ← ON_LEN−1. Otherwise START is ignored.
- ON: operands update every cycle.
  - CNT≠0: decrement CNT.
  - CNT==0 and OFF_LEN≠0: go to OFF, CNT ← OFF_LEN−1.
  - CNT==0 and OFF_LEN==0: stay in ON, CNT ← ON_LEN−1.
- OFF: operands are held. When CNT==0 go to ON with CNT ← ON_LEN−1; otherwise decrement CNT.
- START in ON or OFF restarts at ON with CNT ← ON_LEN−1.
- STOP in any state → IDLE. Operands and sum are retained.
- Writes to ON_LEN or OFF_LEN take effect at the next CNT load. A MODE write takes effect on the next operand update.
- In ON with MODE==0 (MODE written mid-run), operands are held.

Operand update, applied in ON cycles only:
- PIN: A ← `ui_in[6:0]`, B ← `uio_in[6:0]`. Inputs are not synchronized.
- LFSR: Fibonacci, taps 14,13,12,2; shift left; feedback is the XNOR-free XOR of the taps into bit 0. Advances once per ON cycle. A ← next lfsr[6:0], B ← next lfsr[13:7]. The LFSR never reaches zero.
- TOGGLE: A and B both flip between 7'h7F and 7'h00. The first ON cycle after reset or after a MODE write yields 7'h7F.

Sum register: `uo_out` ← {1'b0,A} + {1'b0,B} every enabled cycle.

Reset values:
- State IDLE, CNT = 0, A = B = 0, `uo_out` = 0.
- LFSR = LFSR_SEED; ON_LEN = DEF_ON; OFF_LEN = DEF_OFF; MODE = 0.
- Synchronizer and edge flops = 0, `uio_out` = 0.

## Timing

- Config: with `ui_in[7]` rising before clk edge E1, the write lands at edge E3. `ui_in[6:0]` must be stable from E1 through E3.
- START latency: the START write lands at E3, and the state is ON from E3. The first operand update is at E4, and the matching `uo_out` change at E5.
- Operand-to-sum latency is 1 cycle. BUSY_ON is registered with the state.
- ON lasts exactly ON_LEN cycles; OFF lasts exactly OFF_LEN cycles.
- `ena`=0 freezes the FSM, CNT, LFSR, operands, `uo_out` and config. A strobe edge seen while `ena`=0 is lost.
- `rst_n` low forces reset values immediately and independently of `clk`, even mid-burst or mid-write.

## Test plan

1. Reset with `rst_n` held low, then released → `uo_out`=0, `uio_out`=0, `uio_oe`=8'h80; START with MODE=0 leaves BUSY_ON=0.
2. PIN run: MODE=1, ON_LEN=4, OFF_LEN=0, START; then `ui_in`=8'h7F, `uio_in`=8'h01 → `uo_out`=8'h80 two cycles later, BUSY_ON constantly 1.
3. TOGGLE burst: MODE=3, ON_LEN=3, OFF_LEN=2, START → BUSY_ON repeats 1,1,1,0,0; `uo_out` goes 254,0,254 then holds 254 through OFF.
4. LFSR: MODE=2, ON_LEN=31, OFF_LEN=1, run 500 cycles → zero mismatches against a bench model (taps 14,13,12,2, seed 14'h0001); LFSR never 0; operands frozen in OFF cycles.
5. Commands: data=2'b11 → IDLE; ON_LEN=0 then START → ignored; STOP mid-ON → IDLE next edge with `uo_out` held.
6. Disturbances: `ena`=0 for 5 cycles mid-burst → CNT, BUSY_ON and `uo_out` unchanged, and resume without loss. `rst_n` pulse mid-burst → all reset values, MODE back to 0.
